// File: rtl/ula_pkg.sv
// Shared opcode encodings and FSM state type for the multi-cycle ALU.
package ula_pkg;

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b000001;
    localparam logic [5:0] OP_MULT = 6'b000010;
    localparam logic [5:0] OP_DIV  = 6'b000011;
    localparam logic [5:0] OP_OR   = 6'b000100;
    localparam logic [5:0] OP_AND  = 6'b000101;
    localparam logic [5:0] OP_NOT  = 6'b000110;
    localparam logic [5:0] OP_SLT  = 6'b000111;
    localparam logic [5:0] OP_XOR  = 6'b001000;
    localparam logic [5:0] OP_NOR  = 6'b001001;
    localparam logic [5:0] OP_XNOR = 6'b001010;
    localparam logic [5:0] OP_JAL  = 6'b100000;
    localparam logic [5:0] OP_BEQ  = 6'b100001;
    localparam logic [5:0] OP_BNE  = 6'b100011;
    localparam logic [5:0] OP_SLE  = 6'b100100;
    localparam logic [5:0] OP_SGE  = 6'b100101;

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        MULT   = 2'd1,
        DIV    = 2'd2
    } estado_t;

endpackage

// File: rtl/mult_div_seq.sv
// Iterative datapath: shift-add multiply and restoring divide, one step per clock.
// o_passo is the value the next step will produce, so the caller can capture it on the final edge.
module mult_div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_carregar,
    input  logic             i_modo_div,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_passo,
    output logic             o_ultimo
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] r_acc, r_mcando, r_mcador;
    logic [WIDTH-1:0] r_resto, r_quoc, r_divisor;
    logic             r_modo_div;
    logic [CW-1:0]    r_cont;

    logic [WIDTH-1:0] w_acc_prox;
    logic [WIDTH:0]   w_resto_desl, w_dif;
    logic             w_cabe;
    logic [WIDTH-1:0] w_quoc_prox, w_resto_prox;

    assign w_acc_prox   = r_mcador[0] ? r_acc + r_mcando : r_acc;
    // A non-negative trial difference fits in WIDTH bits, so its top bit is the borrow.
    assign w_resto_desl = {r_resto, r_quoc[WIDTH-1]};
    assign w_dif        = w_resto_desl - {1'b0, r_divisor};
    assign w_cabe       = ~w_dif[WIDTH];
    assign w_quoc_prox  = {r_quoc[WIDTH-2:0], w_cabe};
    assign w_resto_prox = w_cabe ? w_dif[WIDTH-1:0] : w_resto_desl[WIDTH-1:0];

    assign o_passo  = r_modo_div ? w_quoc_prox : w_acc_prox;
    assign o_ultimo = (r_cont == CW'(1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_acc      <= '0;
            r_mcando   <= '0;
            r_mcador   <= '0;
            r_resto    <= '0;
            r_quoc     <= '0;
            r_divisor  <= '0;
            r_modo_div <= 1'b0;
            r_cont     <= '0;
        end else if (i_carregar) begin
            r_acc      <= '0;
            r_mcando   <= i_a;
            r_mcador   <= i_b;
            r_resto    <= '0;
            r_quoc     <= i_a;
            r_divisor  <= i_b;
            r_modo_div <= i_modo_div;
            r_cont     <= CW'(WIDTH);
        end else if (r_cont != '0) begin
            r_cont <= r_cont - CW'(1);
            if (r_modo_div) begin
                r_resto <= w_resto_prox;
                r_quoc  <= w_quoc_prox;
            end else begin
                r_acc    <= w_acc_prox;
                r_mcando <= r_mcando << 1;
                r_mcador <= r_mcador >> 1;
            end
        end
    end

endmodule

// File: rtl/ula_multiciclo.sv
// Multi-cycle ALU: single-cycle ops complete in one edge, mult/div iterate WIDTH edges.
// state  | meaning
// OCIOSO | idle, accepts iniciar; single-cycle ops and divide-by-zero finish here
// MULT   | shift-add multiply iterating
// DIV    | restoring divide iterating
module ula_multiciclo
    import ula_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             iniciar,
    input  logic [5:0]       ALU_Ctrl,
    input  logic [WIDTH-1:0] dados1,
    input  logic [WIDTH-1:0] dados2,
    output logic [WIDTH-1:0] resultado,
    output logic             zero,
    output logic             ocupado,
    output logic             pronto,
    output logic             erro_div
);

    estado_t          r_estado, w_prox;
    logic [WIDTH-1:0] r_resultado;
    logic             r_pronto, r_erro_div;

    logic [WIDTH-1:0] w_simples, w_passo, w_valor;
    logic             w_ultimo, w_carregar, w_modo_div, w_grava, w_aceita, w_erro;

    mult_div_seq #(.WIDTH(WIDTH)) u_seq (
        .clock      (clock),
        .reset      (reset),
        .i_carregar (w_carregar),
        .i_modo_div (w_modo_div),
        .i_a        (dados1),
        .i_b        (dados2),
        .o_passo    (w_passo),
        .o_ultimo   (w_ultimo)
    );

    always_comb begin
        w_simples = '0;
        case (ALU_Ctrl)
            OP_ADD:  w_simples = dados1 + dados2;
            OP_SUB:  w_simples = dados1 - dados2;
            OP_OR:   w_simples = dados1 | dados2;
            OP_AND:  w_simples = dados1 & dados2;
            OP_NOT:  w_simples = ~dados1;
            OP_XOR:  w_simples = dados1 ^ dados2;
            OP_NOR:  w_simples = ~(dados1 | dados2);
            OP_XNOR: w_simples = ~(dados1 ^ dados2);
            OP_SLT:  w_simples = WIDTH'(dados1 < dados2);
            OP_BEQ:  w_simples = WIDTH'(dados1 != dados2);
            OP_BNE:  w_simples = WIDTH'(dados1 == dados2);
            OP_SLE:  w_simples = WIDTH'(dados1 <= dados2);
            OP_SGE:  w_simples = WIDTH'(dados1 >= dados2);
            default: w_simples = '0;
        endcase
    end

    always_comb begin
        w_prox     = r_estado;
        w_carregar = 1'b0;
        w_modo_div = 1'b0;
        w_grava    = 1'b0;
        w_valor    = '0;
        w_aceita   = 1'b0;
        w_erro     = 1'b0;
        case (r_estado)
            OCIOSO: begin
                if (iniciar) begin
                    w_aceita = 1'b1;
                    if (ALU_Ctrl == OP_MULT) begin
                        w_carregar = 1'b1;
                        w_prox     = MULT;
                    end else if (ALU_Ctrl == OP_DIV) begin
                        if (dados2 == '0) begin
                            w_grava = 1'b1;
                            w_valor = '1;
                            w_erro  = 1'b1;
                        end else begin
                            w_carregar = 1'b1;
                            w_modo_div = 1'b1;
                            w_prox     = DIV;
                        end
                    end else begin
                        w_grava = 1'b1;
                        w_valor = w_simples;
                    end
                end
            end
            MULT, DIV: begin
                if (w_ultimo) begin
                    w_grava = 1'b1;
                    w_valor = w_passo;
                    w_prox  = OCIOSO;
                end
            end
            default: w_prox = OCIOSO;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_estado    <= OCIOSO;
            r_resultado <= '0;
            r_pronto    <= 1'b0;
            r_erro_div  <= 1'b0;
        end else begin
            r_estado <= w_prox;
            r_pronto <= w_grava;
            if (w_grava)
                r_resultado <= w_valor;
            if (w_aceita)
                r_erro_div <= w_erro;
        end
    end

    assign resultado = r_resultado;
    assign zero      = (r_resultado == '0);
    assign ocupado   = (r_estado != OCIOSO);
    assign pronto    = r_pronto;
    assign erro_div  = r_erro_div;

endmodule

// File: tb/tb_ula_multiciclo.sv
// Scoreboard bench for ula_multiciclo: WIDTH=32 main instance plus a WIDTH=8 multiply instance.
module tb_ula_multiciclo;
    import ula_pkg::*;

    typedef struct {
        logic [31:0] res;
        logic        erro;
    } esp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        iniciar = 1'b0;
    logic [5:0]  ALU_Ctrl = '0;
    logic [31:0] dados1 = '0, dados2 = '0;
    logic [31:0] resultado;
    logic        zero, ocupado, pronto, erro_div;

    logic        iniciar8 = 1'b0;
    logic [5:0]  ctrl8 = '0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [7:0]  res8;
    logic        zero8, ocup8, pronto8, erro8;

    int   n_checks = 0;
    int   n_erros  = 0;
    int   n_push   = 0;
    int   n_pronto = 0;
    int   n;
    esp_t fila[$];

    always #5 clock = ~clock;

    ula_multiciclo #(.WIDTH(32)) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .ALU_Ctrl(ALU_Ctrl),
        .dados1(dados1), .dados2(dados2), .resultado(resultado), .zero(zero),
        .ocupado(ocupado), .pronto(pronto), .erro_div(erro_div)
    );

    ula_multiciclo #(.WIDTH(8)) dut8 (
        .clock(clock), .reset(reset), .iniciar(iniciar8), .ALU_Ctrl(ctrl8),
        .dados1(a8), .dados2(b8), .resultado(res8), .zero(zero8),
        .ocupado(ocup8), .pronto(pronto8), .erro_div(erro8)
    );

    task automatic verifica(input string tag, input logic [63:0] obs, input logic [63:0] esp);
        n_checks++;
        if (obs !== esp) begin
            n_erros++;
            $display("FAIL %s: obtido=%0h esperado=%0h", tag, obs, esp);
        end
    endtask

    function automatic esp_t modelo(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        esp_t e;
        e.erro = 1'b0;
        e.res  = '0;
        case (op)
            OP_ADD:  e.res = a + b;
            OP_SUB:  e.res = a - b;
            OP_MULT: e.res = a * b;
            OP_DIV:  if (b == 0) begin e.res = 32'hFFFF_FFFF; e.erro = 1'b1; end
                     else e.res = a / b;
            OP_OR:   e.res = a | b;
            OP_AND:  e.res = a & b;
            OP_NOT:  e.res = ~a;
            OP_XOR:  e.res = a ^ b;
            OP_NOR:  e.res = ~(a | b);
            OP_XNOR: e.res = ~(a ^ b);
            OP_SLT:  e.res = (a < b) ? 32'd1 : 32'd0;
            OP_BEQ:  e.res = (a == b) ? 32'd0 : 32'd1;
            OP_BNE:  e.res = (a != b) ? 32'd0 : 32'd1;
            OP_SLE:  e.res = (a <= b) ? 32'd1 : 32'd0;
            OP_SGE:  e.res = (a >= b) ? 32'd1 : 32'd0;
            default: e.res = '0;
        endcase
        return e;
    endfunction

    // Called at a falling edge; returns at the falling edge right after the acceptance edge.
    task automatic inicia(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b, input bit registra);
        iniciar  = 1'b1;
        ALU_Ctrl = op;
        dados1   = a;
        dados2   = b;
        if (registra) begin
            fila.push_back(modelo(op, a, b));
            n_push++;
        end
        @(negedge clock);
        iniciar = 1'b0;
        dados1  = $urandom;
        dados2  = $urandom;
    endtask

    task automatic espera(input string tag, output int ciclos);
        int guarda = 0;
        ciclos = 0;
        while (!pronto && guarda < 200) begin
            if (ocupado) ciclos++;
            @(negedge clock);
            guarda++;
        end
        verifica(tag, 64'(pronto), 64'd1);
    endtask

    always @(negedge clock) begin
        esp_t e;
        if (pronto) begin
            n_pronto++;
            verifica("ocupado_em_pronto", 64'(ocupado), 64'd0);
            if (fila.size() == 0) begin
                verifica("pronto_sem_pedido", 64'(fila.size()), 64'd1);
            end else begin
                e = fila.pop_front();
                verifica("resultado", 64'(resultado), 64'(e.res));
                verifica("zero", 64'(zero), 64'(e.res == 0));
                verifica("erro_div", 64'(erro_div), 64'(e.erro));
            end
        end
    end

    initial begin
        repeat (2) @(negedge clock);
        verifica("rst_resultado", 64'(resultado), 64'd0);
        verifica("rst_zero", 64'(zero), 64'd1);
        verifica("rst_ocupado", 64'(ocupado), 64'd0);
        verifica("rst_pronto", 64'(pronto), 64'd0);
        reset = 1'b0;
        @(negedge clock);

        inicia(OP_ADD, 32'd5, 32'd7, 1'b1);
        verifica("add_pronto", 64'(pronto), 64'd1);
        verifica("add_12", 64'(resultado), 64'd12);
        verifica("add_zero", 64'(zero), 64'd0);
        @(negedge clock);
        verifica("add_pronto_pulso", 64'(pronto), 64'd0);

        inicia(OP_MULT, 32'hFFFF_FFFF, 32'd3, 1'b1);
        espera("mult_timeout", n);
        verifica("mult_lat", 64'(n), 64'd32);
        verifica("mult_val", 64'(resultado), 64'hFFFF_FFFD);
        @(negedge clock);

        inicia(OP_DIV, 32'd100, 32'd7, 1'b1);
        espera("div_timeout", n);
        verifica("div_lat", 64'(n), 64'd32);
        verifica("div_val", 64'(resultado), 64'd14);
        @(negedge clock);

        inicia(OP_DIV, 32'd9, 32'd0, 1'b1);
        espera("div0_timeout", n);
        verifica("div0_lat", 64'(n), 64'd0);
        verifica("div0_erro", 64'(erro_div), 64'd1);
        verifica("div0_val", 64'(resultado), 64'hFFFF_FFFF);
        @(negedge clock);

        // Start while busy must be dropped; a start in the pronto cycle must be taken.
        inicia(OP_MULT, 32'd6, 32'd7, 1'b1);
        repeat (4) @(negedge clock);
        inicia(OP_ADD, 32'd1, 32'd1, 1'b0);
        espera("busy_timeout", n);
        verifica("busy_val", 64'(resultado), 64'd42);
        inicia(OP_XOR, 32'hF0F0_0000, 32'h0FF0_1234, 1'b1);
        verifica("b2b_pronto", 64'(pronto), 64'd1);
        inicia(OP_SUB, 32'd10, 32'd4, 1'b1);
        verifica("b2b_seq_pronto", 64'(pronto), 64'd1);
        @(negedge clock);

        inicia(OP_DIV, 32'd1000, 32'd3, 1'b0);
        repeat (9) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        verifica("rstmid_resultado", 64'(resultado), 64'd0);
        verifica("rstmid_zero", 64'(zero), 64'd1);
        verifica("rstmid_ocupado", 64'(ocupado), 64'd0);
        verifica("rstmid_pronto", 64'(pronto), 64'd0);
        verifica("rstmid_erro", 64'(erro_div), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (40) @(negedge clock);
        verifica("rstmid_ocioso", 64'(ocupado), 64'd0);
        inicia(OP_SUB, 32'd3, 32'd5, 1'b1);
        verifica("sub_val", 64'(resultado), 64'hFFFF_FFFE);
        @(negedge clock);

        inicia(OP_BEQ, 32'd8, 32'd8, 1'b1);
        verifica("beq_zero", 64'(zero), 64'd1);
        inicia(OP_SGE, 32'd3, 32'd9, 1'b1);
        verifica("sge_val", 64'(resultado), 64'd0);
        inicia(6'b111111, 32'd12, 32'd34, 1'b1);
        verifica("undef_val", 64'(resultado), 64'd0);
        inicia(OP_BNE, 32'd8, 32'd9, 1'b1);
        inicia(OP_SLT, 32'd2, 32'd9, 1'b1);
        inicia(OP_SLE, 32'd5, 32'd5, 1'b1);
        inicia(OP_NOR, 32'h0000_FFFF, 32'h00FF_0000, 1'b1);
        inicia(OP_XNOR, 32'h1234_5678, 32'h1234_5678, 1'b1);
        inicia(OP_NOT, 32'h0F0F_0F0F, 32'd0, 1'b1);
        inicia(OP_AND, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b1);
        inicia(OP_OR, 32'hFF00_0000, 32'h0000_00FF, 1'b1);
        inicia(OP_JAL, 32'd77, 32'd88, 1'b1);
        inicia(OP_MULT, 32'h0001_2345, 32'h0000_0100, 1'b1);
        espera("mult2_timeout", n);
        @(negedge clock);
        inicia(OP_DIV, 32'hFFFF_FFFF, 32'd16, 1'b1);
        espera("div2_timeout", n);
        @(negedge clock);

        iniciar8 = 1'b1;
        ctrl8    = OP_MULT;
        a8       = 8'hFF;
        b8       = 8'hFF;
        @(negedge clock);
        iniciar8 = 1'b0;
        n = 0;
        for (int g = 0; g < 50 && !pronto8; g++) begin
            if (ocup8) n++;
            @(negedge clock);
        end
        verifica("mult8_pronto", 64'(pronto8), 64'd1);
        verifica("mult8_lat", 64'(n), 64'd8);
        verifica("mult8_val", 64'(res8), 64'h01);
        verifica("mult8_erro", 64'(erro8), 64'd0);
        verifica("mult8_zero", 64'(zero8), 64'd0);

        repeat (3) @(negedge clock);
        verifica("fila_vazia", 64'(fila.size()), 64'd0);
        verifica("n_pronto", 64'(n_pronto), 64'(n_push));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_erros);
        $finish;
    end

endmodule

// File: doc/ula_multiciclo.md
# ula_multiciclo

Parametrised multi-cycle successor to the processor's single-cycle ALU. It keeps the same 6-bit operation encoding and `zero` flag, generalises data width, and replaces combinational multiply/divide with iterative shift-add and restoring-division units. A start/busy/done handshake lets the control unit stall the datapath. It sits in the execute stage between the register-file read ports and the write-back mux, and registers every result.

## Interface

**Parameters**
- `WIDTH`, default 32: operand and result width; legal range 4..64.

**Ports**
- `clock`, in, 1: single clock; rising edge.
- `reset`, in, 1: asynchronous, active-high.
- `iniciar`, in, 1: start request. Sampled only while `ocupado`=0.
- `ALU_Ctrl`, in, 6: operation code, latched with `iniciar`.
- `dados1`, in, WIDTH: operand A, latched with `iniciar`.
- `dados2`, in, WIDTH: operand B, latched with `iniciar`.
- `resultado`, out, WIDTH: registered result; holds its value until the next completion.
- `zero`, out, 1: equals (`resultado`==0); decoded from the register, so no extra latency.
- `ocupado`, out, 1: high while a multiply or divide is iterating.
- `pronto`, out, 1: one-cycle pulse on every completion.
- `erro_div`, out, 1: set with `pronto` when a divide has `dados2`=0; cleared on the next accepted start.

## Operation

- **Operation codes**, all unsigned:
  - 000000 add; 000001 sub; 000010 mult (low WIDTH bits); 000011 div (quotient).
  - 000100 or; 000101 and; 000110 not A; 001000 xor (A^B); 001001 nor; 001010 xnor.
  - 000111 slt.
  - 100000 jal (result 0); 100001 beq (0 if A==B, else 1); 100011 bne (0 if A!=B, else 1).
  - 100100 sle; 100101 sge.
  - Any other code: result 0.
- **Arithmetic:** add/sub wrap modulo 2^WIDTH; no carry or overflow outputs.
- **States:** OCIOSO, MULT, DIV.
  - OCIOSO with `iniciar`=1:
    - mult: go to MULT and load the iteration counter with WIDTH.
    - div with `dados2`≠0: go to DIV and load the iteration counter with WIDTH.
    - div with `dados2`=0: stay in OCIOSO; write `resultado`=all ones; pulse `pronto`; set `erro_div`.
    - Every other code: stay in OCIOSO; write `resultado`; pulse `pronto`.
  - MULT: one shift-add step per cycle. When the counter reaches 0: write the result, pulse `pronto`, return to OCIOSO.
  - DIV: one restoring step per cycle. When the counter reaches 0: write the result, pulse `pronto`, return to OCIOSO.
- **Busy handling:** `iniciar` during MULT or DIV is ignored; the request is not queued. The operand pins may change freely once the start has been accepted.
- **Reset:** async assertion at any point, including mid-iteration, forces:
  - state OCIOSO;
  - `resultado`=0, so `zero`=1;
  - `ocupado`=0, `pronto`=0, `erro_div`=0;
  - counters and partial registers cleared.
  - Any in-flight operation is discarded without a `pronto`.

## Timing

- A start is accepted at rising edge k when `iniciar`=1 and `ocupado`=0.
- **Single-cycle ops and divide-by-zero:** `resultado` and `pronto` are valid after edge k. `pronto` is high for cycle k+1 only.
- **mult/div:**
  - `ocupado` rises after edge k.
  - Iterations run on edges k+1 .. k+WIDTH.
  - After edge k+WIDTH: `resultado` is updated, `pronto` is high for one cycle, and `ocupado` falls.
  - Latency is WIDTH+1 edges from acceptance.
- **Back-to-back:** a new start is accepted in the same cycle `pronto` is high, because `ocupado` is already 0. Single-cycle ops therefore sustain one per clock.
- `resultado` never changes except at a completion or at reset.

## Structure

- **Shared package `ula_pkg`:**
  - the 6-bit opcode localparams (`OP_ADD` … `OP_SGE`);
  - the state enum `{OCIOSO, MULT, DIV}`.
- **Sub-module `mult_div_seq`:** holds the iterative datapath (accumulator, shifted operand, remainder/quotient registers, counter), selected by a mode bit. The top level owns the FSM, the combinational single-cycle operations, and the output registers.
- One clock domain; no memories.

## Test plan

- **Reset value:** assert `reset` → `resultado`=0, `zero`=1, `ocupado`=0, `pronto`=0. Deassert, apply add 5+7 → after one edge `resultado`=12, `pronto`=1 for one cycle, `zero`=0.
- **Multiply:** 0xFFFF_FFFF × 3 (WIDTH=32) → `ocupado` high for 32 cycles, then `resultado`=0xFFFF_FFFD and a single `pronto` at edge k+32.
- **Divide:** 100 / 7 → `resultado`=14 after 32 iterations, `erro_div`=0. Then 9 / 0 → `resultado`=0xFFFF_FFFF, `erro_div`=1, `pronto` after one edge.
- **Start while busy:** pulse `iniciar` with add 1+1 during a multiply → ignored; only the multiply result appears. A start issued in the `pronto` cycle is accepted.
- **Reset mid-operation:** assert `reset` at iteration 10 of a divide → all outputs return to reset values immediately, with no `pronto`. A new sub 3−5 afterwards gives `resultado`=0xFFFF_FFFE.
- **Flags and compares:** beq 8,8 → `resultado`=0, `zero`=1. sge 3,9 → 0. Undefined opcode 111111 → 0. Repeat the multiply check with WIDTH=8: 0xFF × 0xFF → 0x01 after 8 iterations.
